// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches sequential words over a single-outstanding
// req/gnt/rvalid handshake and hands {pc, instr} pairs to the core in order.
// A redirect flushes everything queued and restarts fetch at the new pc.
// Any response already in flight when a redirect arrives is discarded.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [31:0]              imem_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [31:0]   NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetchState;

   fetchState      stateReg, stateNext;
   logic [31:0]    fetchPcReg, fetchPcNext;
   logic [CW-1:0]  countReg, countNext;
   logic [PW-1:0]  rdPtrReg, wrPtrReg;
   logic [63:0]    entryMem [DEPTH];
   logic [63:0]    headEntry;
   logic           pushEn, popEn;
   logic [CW-1:0]  postPushCount;

   // A response lands in the queue only in WAIT and only when no redirect overrides it.
   assign pushEn        = (stateReg == WAIT) & imem_rvalid & ~redirect;
   assign popEn         = out_valid & out_ready & ~redirect;
   assign postPushCount = countReg + CW'(1) - CW'(popEn);

   // Occupancy and fetch pc; redirect wins over push and pop.
   always_comb begin
      countNext   = countReg + CW'(pushEn) - CW'(popEn);
      fetchPcNext = fetchPcReg;
      if (pushEn) begin
         fetchPcNext = fetchPcReg + 32'd4;
      end
      if (redirect) begin
         countNext   = '0;
         fetchPcNext = {redirect_pc[31:2], 2'b00};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Queue pointers, occupancy and fetch pc.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetchPcReg <= RESET_PC;
         countReg   <= '0;
         rdPtrReg   <= '0;
         wrPtrReg   <= '0;
      end else begin
         fetchPcReg <= fetchPcNext;
         countReg   <= countNext;
         if (redirect) begin
            rdPtrReg <= '0;
            wrPtrReg <= '0;
         end else begin
            if (pushEn) wrPtrReg <= wrPtrReg + PW'(1);
            if (popEn)  rdPtrReg <= rdPtrReg + PW'(1);
         end
      end
   end

   // Entry storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (pushEn) begin
         entryMem[wrPtrReg] <= {fetchPcReg, imem_rdata};
      end
   end

   // Next-state logic; a redirect turns any in-flight response into a stale one.
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE: begin
            if (redirect || countReg < FULL) stateNext = REQ;
         end
         REQ: begin
            if (imem_gnt) stateNext = redirect ? DROP : WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (redirect || postPushCount < FULL) stateNext = REQ;
               else                                   stateNext = IDLE;
            end else if (redirect) begin
               stateNext = DROP;
            end
         end
         DROP: begin
            if (imem_rvalid) stateNext = REQ;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Output logic: request side from state, core side from the queue head.
   always_comb begin
      imem_req  = (stateReg == REQ);
      imem_addr = fetchPcReg;
      headEntry = entryMem[rdPtrReg];
      out_valid = (countReg != '0);
      out_pc    = out_valid ? headEntry[63:32] : 32'h0;
      out_instr = out_valid ? headEntry[31:0]  : NOP;
      count     = countReg;
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a fixed cycle table for fill/stall/refill, hand sequences
// for redirect and reset corners, and a randomized run against a queue-based model.
module tb_ifetch_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Instruction memory content: a function of the address, never a NOP.
   function automatic logic [31:0] fInstr(input logic [31:0] a);
      return (a ^ 32'hC0DE_0000) + 32'h0000_0100;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit g, input bit r, input logic [31:0] d, input bit rd,
                      input bit rx, input logic [31:0] rp);
      imem_gnt    = g;
      imem_rvalid = r;
      imem_rdata  = d;
      out_ready   = rd;
      redirect    = rx;
      redirect_pc = rp;
      @(negedge clk);
   endtask

   task automatic doReset();
      reset = 1'b0;
      imem_gnt = 0; imem_rvalid = 0; out_ready = 0; redirect = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic waitReq();
      int n = 0;
      while (!imem_req && n < 20) begin
         cyc(0, 0, 32'h0, 0, 0, 32'h0);
         n++;
      end
      if (!imem_req) chk("waitReq", {31'b0, imem_req}, 32'd1);
   endtask

   task automatic fetchOne();
      logic [31:0] a;
      waitReq();
      a = imem_addr;
      cyc(1, 0, 32'h0, 0, 0, 32'h0);
      cyc(0, 1, fInstr(a), 0, 0, 32'h0);
   endtask

   typedef struct {
      bit          gnt;
      bit          rv;
      bit          ready;
      bit          expReq;
      logic [31:0] expAddr;
      bit          expValid;
      logic [31:0] expPc;
      int          expCount;
   } vecT;

   function automatic vecT mk(bit g, bit r, bit rd, bit q, logic [31:0] a, bit v,
                              logic [31:0] p, int c);
      vecT t;
      t.gnt = g; t.rv = r; t.ready = rd; t.expReq = q; t.expAddr = a;
      t.expValid = v; t.expPc = p; t.expCount = c;
      return t;
   endfunction

   vecT tbl [14];

   initial begin
      logic [31:0] lastGnt;
      logic [31:0] modelQ [$];
      logic [31:0] outAddr, nextPc, prevAddr, a, rp, d;
      int outstanding, outStale, delay, pops;
      bit prevHold, q, g, r, rd, rx;

      // Fill four entries with the core stalled, pop one, see the refill at 0x10.
      tbl[0]  = mk(1, 0, 0, 0, 32'h00, 0, 32'h0, 0);
      tbl[1]  = mk(1, 0, 0, 1, 32'h00, 0, 32'h0, 0);
      tbl[2]  = mk(0, 1, 0, 0, 32'h00, 0, 32'h0, 0);
      tbl[3]  = mk(1, 0, 0, 1, 32'h04, 1, 32'h0, 1);
      tbl[4]  = mk(0, 1, 0, 0, 32'h04, 1, 32'h0, 1);
      tbl[5]  = mk(1, 0, 0, 1, 32'h08, 1, 32'h0, 2);
      tbl[6]  = mk(0, 1, 0, 0, 32'h08, 1, 32'h0, 2);
      tbl[7]  = mk(1, 0, 0, 1, 32'h0C, 1, 32'h0, 3);
      tbl[8]  = mk(0, 1, 0, 0, 32'h0C, 1, 32'h0, 3);
      tbl[9]  = mk(0, 0, 1, 0, 32'h10, 1, 32'h0, 4);
      tbl[10] = mk(0, 0, 0, 0, 32'h10, 1, 32'h4, 3);
      tbl[11] = mk(1, 0, 0, 1, 32'h10, 1, 32'h4, 3);
      tbl[12] = mk(0, 1, 0, 0, 32'h10, 1, 32'h4, 3);
      tbl[13] = mk(0, 0, 0, 0, 32'h14, 1, 32'h4, 4);

      @(negedge clk);
      doReset();
      lastGnt = 32'h0;
      for (int i = 0; i < 14; i++) begin
         $display("row %0d req=%b addr=%h valid=%b pc=%h count=%0d",
                  i, imem_req, imem_addr, out_valid, out_pc, count);
         chk($sformatf("row%0d_req", i),   {31'b0, imem_req}, {31'b0, tbl[i].expReq});
         chk($sformatf("row%0d_addr", i),  imem_addr, tbl[i].expAddr);
         chk($sformatf("row%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].expValid});
         chk($sformatf("row%0d_pc", i),    out_pc, tbl[i].expValid ? tbl[i].expPc : 32'h0);
         chk($sformatf("row%0d_instr", i), out_instr,
             tbl[i].expValid ? fInstr(tbl[i].expPc) : NOP);
         chk($sformatf("row%0d_count", i), {29'b0, count}, 32'(tbl[i].expCount));
         d = fInstr(lastGnt);
         if (tbl[i].expReq && tbl[i].gnt) lastGnt = tbl[i].expAddr;
         cyc(tbl[i].gnt, tbl[i].rv, d, tbl[i].ready, 0, 32'h0);
      end

      // Redirect coinciding with rvalid and out_ready: nothing pushed or popped.
      doReset();
      fetchOne();
      waitReq();
      cyc(1, 0, 32'h0, 0, 0, 32'h0);
      cyc(0, 1, fInstr(32'h4), 1, 1, 32'h0000_0200);
      $display("redirect+rvalid count=%0d req=%b addr=%h", count, imem_req, imem_addr);
      chk("rdrRv_count", {29'b0, count}, 32'd0);
      chk("rdrRv_valid", {31'b0, out_valid}, 32'd0);
      chk("rdrRv_req",   {31'b0, imem_req}, 32'd1);
      chk("rdrRv_addr",  imem_addr, 32'h0000_0200);

      // Grant withheld: request and address hold, then a redirect moves the address.
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold%0d_req", i),  {31'b0, imem_req}, 32'd1);
         chk($sformatf("hold%0d_addr", i), imem_addr, 32'h0000_0200);
         cyc(0, 0, 32'h0, 0, 0, 32'h0);
      end
      cyc(0, 0, 32'h0, 0, 1, 32'h0000_0303);
      $display("hold redirect req=%b addr=%h", imem_req, imem_addr);
      chk("holdRdr_req",  {31'b0, imem_req}, 32'd1);
      chk("holdRdr_addr", imem_addr, 32'h0000_0300);

      // Redirect in WAIT with a late response: the stale word is dropped.
      cyc(1, 0, 32'h0, 0, 0, 32'h0);
      chk("drop_waitReq", {31'b0, imem_req}, 32'd0);
      cyc(0, 0, 32'h0, 0, 1, 32'h0000_0102);
      chk("drop_count", {29'b0, count}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("drop%0d_req", i), {31'b0, imem_req}, 32'd0);
         cyc(0, 0, 32'h0, 0, 0, 32'h0);
      end
      chk("drop_noReq", {31'b0, imem_req}, 32'd0);
      cyc(0, 1, 32'hBAD0_BAD0, 0, 0, 32'h0);
      $display("after drop req=%b addr=%h count=%0d", imem_req, imem_addr, count);
      chk("drop_req",    {31'b0, imem_req}, 32'd1);
      chk("drop_addr",   imem_addr, 32'h0000_0100);
      chk("drop_empty",  {29'b0, count}, 32'd0);
      cyc(1, 0, 32'h0, 0, 0, 32'h0);
      cyc(0, 1, fInstr(32'h100), 0, 0, 32'h0);
      chk("drop_outValid", {31'b0, out_valid}, 32'd1);
      chk("drop_outPc",    out_pc, 32'h0000_0100);
      chk("drop_outInstr", out_instr, fInstr(32'h100));

      // Reset asserted mid-WAIT with three entries queued.
      doReset();
      repeat (3) fetchOne();
      waitReq();
      cyc(1, 0, 32'h0, 0, 0, 32'h0);
      chk("rst_preCount", {29'b0, count}, 32'd3);
      #2;
      reset = 1'b0;
      #1;
      $display("async reset req=%b addr=%h valid=%b count=%0d", imem_req, imem_addr, out_valid, count);
      chk("rst_req",   {31'b0, imem_req}, 32'd0);
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_pc",    out_pc, 32'h0);
      chk("rst_instr", out_instr, NOP);
      chk("rst_count", {29'b0, count}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      waitReq();
      chk("rst_firstAddr", imem_addr, 32'h0);

      // Randomized run against a queue model of the architectural stream.
      doReset();
      modelQ.delete();
      outstanding = 0; outStale = 0; delay = 0; pops = 0;
      nextPc = 32'h0; prevHold = 0; prevAddr = 32'h0; outAddr = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         chk("rndCount", {29'b0, count}, 32'(modelQ.size()));
         chk("rndValid", {31'b0, out_valid}, {31'b0, modelQ.size() != 0});
         if (modelQ.size() != 0) begin
            chk("rndPc",    out_pc, modelQ[0]);
            chk("rndInstr", out_instr, fInstr(modelQ[0]));
         end else begin
            chk("rndPcEmpty",    out_pc, 32'h0);
            chk("rndInstrEmpty", out_instr, NOP);
         end
         if (prevHold) begin
            chk("rndHoldReq",  {31'b0, imem_req}, 32'd1);
            chk("rndHoldAddr", imem_addr, prevAddr);
         end
         chk("rndOneOutstanding", {31'b0, imem_req && (outstanding != 0)}, 32'd0);

         rx = ($urandom_range(0, 19) == 0);
         rp = $urandom;
         rd = ($urandom_range(0, 2) != 0);
         g  = $urandom_range(0, 1) == 1;
         r  = (outstanding != 0) && (delay == 0);
         d  = r ? fInstr(outAddr) : $urandom;
         q  = imem_req;
         a  = imem_addr;
         imem_gnt = g; imem_rvalid = r; imem_rdata = d;
         out_ready = rd; redirect = rx; redirect_pc = rp;

         if (modelQ.size() != 0 && rd && !rx) begin
            void'(modelQ.pop_front());
            pops++;
         end
         if (r) begin
            if (outStale == 0 && !rx) begin
               chk("rndPushPc", outAddr, nextPc);
               modelQ.push_back(outAddr);
               nextPc = nextPc + 32'd4;
            end
            outstanding = 0;
         end else if (outstanding != 0 && delay > 0) begin
            delay--;
         end
         if (rx) begin
            modelQ.delete();
            nextPc = rp & ~32'h3;
            if (outstanding != 0) outStale = 1;
         end
         if (q && g) begin
            outstanding = 1;
            outStale    = rx ? 1 : 0;
            outAddr     = a;
            delay       = $urandom_range(0, 3);
         end
         prevHold = q && !g && !rx;
         prevAddr = a;
         @(negedge clk);
      end
      $display("random run pops=%0d", pops);
      chk("rndProgress", {31'b0, pops > 100}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
